// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA sync generator with pixel clock-enable divider,
//            registered sync/blank decode and optional sync delay line.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 0,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             line_start,
    output logic             frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_h_last   = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0]   c_v_last   = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0]   c_h_act    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]   c_v_act    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]   c_hs_start = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]   c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]   c_vs_start = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]   c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_div_w-1:0] r_div;
    logic [CNT_W-1:0]   r_hcount;
    logic [CNT_W-1:0]   r_vcount;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank;
    logic               r_line_start;
    logic               r_frame_start;

    logic [CNT_W-1:0]   w_h_next;
    logic [CNT_W-1:0]   w_v_next;
    logic               w_hs_act;
    logic               w_vs_act;
    logic               w_blank;

    // With CLK_DIV=1 the divider is pinned at zero, so pix_ce collapses to en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
        end
    end

    assign pix_ce = en && (r_div == c_div_last);

    always_comb begin
        w_h_next = r_hcount + 1'b1;
        w_v_next = r_vcount;
        if (r_hcount == c_h_last) begin
            w_h_next = '0;
            w_v_next = (r_vcount == c_v_last) ? '0 : r_vcount + 1'b1;
        end
    end

    // Decode looks at the position being entered so sync/blank land on the
    // same edge as the counters rather than one pixel late.
    assign w_hs_act = (w_h_next >= c_hs_start) && (w_h_next < c_hs_end);
    assign w_vs_act = (w_v_next >= c_vs_start) && (w_v_next < c_vs_end);
    assign w_blank  = (w_h_next >= c_h_act) || (w_v_next >= c_v_act);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= c_h_last;
            r_vcount      <= c_v_last;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (pix_ce) begin
                r_hcount      <= w_h_next;
                r_vcount      <= w_v_next;
                r_hs          <= w_hs_act ? HS_POL : ~HS_POL;
                r_vs          <= w_vs_act ? VS_POL : ~VS_POL;
                r_blank       <= w_blank;
                r_line_start  <= (w_h_next == '0);
                r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
            end
        end
    end

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync = r_hs;
            assign vsync = r_vs;
            assign blank = r_blank;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] r_hs_dly;
            logic [SYNC_DELAY-1:0] r_vs_dly;
            logic [SYNC_DELAY-1:0] r_blank_dly;

            // Stages advance on pixel ticks so the lag is counted in pixels.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_hs_dly    <= {SYNC_DELAY{~HS_POL}};
                    r_vs_dly    <= {SYNC_DELAY{~VS_POL}};
                    r_blank_dly <= {SYNC_DELAY{1'b1}};
                end else if (pix_ce) begin
                    r_hs_dly[0]    <= r_hs;
                    r_vs_dly[0]    <= r_vs;
                    r_blank_dly[0] <= r_blank;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_hs_dly[i]    <= r_hs_dly[i-1];
                        r_vs_dly[i]    <= r_vs_dly[i-1];
                        r_blank_dly[i] <= r_blank_dly[i-1];
                    end
                end
            end

            assign hsync = r_hs_dly[SYNC_DELAY-1];
            assign vsync = r_vs_dly[SYNC_DELAY-1];
            assign blank = r_blank_dly[SYNC_DELAY-1];
        end
    endgenerate

endmodule
`default_nettype wire
